// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote mid-bit sampling, per-character
// frame/parity error tags and a first-word fall-through RX FIFO with overrun flag.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd_en,
  output logic [DATA_BITS-1:0]              data,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overrun,
  input  logic                              ovr_clr,
  output logic                              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   fe_q, fe_d, pe_q, pe_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
  logic                   overrun_q, overrun_d;
  logic                   vote_pt, voted, do_wr, do_rd;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head;

  assign vote_pt = (cnt_q == MID + CW'(1));
  assign voted   = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    samp_d    = samp_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    sh_d      = sh_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    wr_pend_d = 1'b0;
    if (cnt_q == MID - CW'(1)) samp_d[1] = rxs_q;
    if (cnt_q == MID)          samp_d[0] = rxs_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) begin
          state_d = S_START;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
          bit_d   = '0;
          stop_d  = 1'b0;
        end
      end
      S_START: begin
        // Counter was zeroed at the falling edge, so later votes already sit at bit centres.
        if (vote_pt) state_d = voted ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (vote_pt) begin
          sh_d = {voted, sh_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                            bit_d   = bit_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (vote_pt) begin
          pe_d    = ((^sh_q) ^ voted) != (PARITY == 1);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_pt) begin
          if (!voted) fe_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            wr_pend_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_pend_q && (!full || do_rd);

  always_comb begin
    wr_ptr_d  = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overrun_d = ovr_clr ? 1'b0 : overrun_q;
    if (wr_pend_q && full && !do_rd) overrun_d = 1'b1;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      cnt_q      <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      sh_q       <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      sh_q       <= sh_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      wr_pend_q  <= wr_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= {sh_q, fe_q, pe_q};
  end

  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign data       = empty ? '0 : head[EW-1:2];
  assign frame_err  = !empty && head[1];
  assign parity_err = !empty && head[0];
  assign count      = fill;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Drives three differently configured receivers with directed and random frames and
// compares their FIFO outputs against a queue-based character model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB [3] = '{104, 16, 12};
  localparam int DB  [3] = '{8, 7, 9};
  localparam int PAR [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 2, 1};
  localparam int DEP [3] = '{16, 4, 2};

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx_v, rd_v, oc_v;
  wire  [7:0] data0;
  wire  [6:0] data1;
  wire  [8:0] data2;
  wire  [4:0] cnt0;
  wire  [2:0] cnt1;
  wire  [1:0] cnt2;
  wire  [2:0] fe_v, pe_v, em_v, fu_v, ov_v, bz_v;

  ent_t mq [3][$];
  bit   ovr_m [3];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .rd_en(rd_v[0]), .data(data0), .frame_err(fe_v[0]),
    .parity_err(pe_v[0]), .empty(em_v[0]), .full(fu_v[0]), .count(cnt0), .overrun(ov_v[0]),
    .ovr_clr(oc_v[0]), .busy(bz_v[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .rd_en(rd_v[1]), .data(data1), .frame_err(fe_v[1]),
    .parity_err(pe_v[1]), .empty(em_v[1]), .full(fu_v[1]), .count(cnt1), .overrun(ov_v[1]),
    .ovr_clr(oc_v[1]), .busy(bz_v[1]));

  uart_rx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .rd_en(rd_v[2]), .data(data2), .frame_err(fe_v[2]),
    .parity_err(pe_v[2]), .empty(em_v[2]), .full(fu_v[2]), .count(cnt2), .overrun(ov_v[2]),
    .ovr_clr(oc_v[2]), .busy(bz_v[2]));

  function automatic int get_data(input int u);
    case (u)
      0:       return int'(data0);
      1:       return int'(data1);
      default: return int'(data2);
    endcase
  endfunction

  function automatic int get_count(input int u);
    case (u)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_state(input int u, input string tag);
    int sz;
    sz = mq[u].size();
    check($sformatf("u%0d.%s.count", u, tag), get_count(u), sz);
    check($sformatf("u%0d.%s.empty", u, tag), int'(em_v[u]), int'(sz == 0));
    check($sformatf("u%0d.%s.full", u, tag), int'(fu_v[u]), int'(sz == DEP[u]));
    check($sformatf("u%0d.%s.overrun", u, tag), int'(ov_v[u]), int'(ovr_m[u]));
    check($sformatf("u%0d.%s.busy", u, tag), int'(bz_v[u]), 0);
    if (sz > 0) begin
      check($sformatf("u%0d.%s.data", u, tag), get_data(u), int'(mq[u][0].d));
      check($sformatf("u%0d.%s.frame_err", u, tag), int'(fe_v[u]), int'(mq[u][0].fe));
      check($sformatf("u%0d.%s.parity_err", u, tag), int'(pe_v[u]), int'(mq[u][0].pe));
    end
  endtask

  task automatic reset_check(input int u, input string tag);
    check($sformatf("u%0d.%s.count", u, tag), get_count(u), 0);
    check($sformatf("u%0d.%s.empty", u, tag), int'(em_v[u]), 1);
    check($sformatf("u%0d.%s.full", u, tag), int'(fu_v[u]), 0);
    check($sformatf("u%0d.%s.overrun", u, tag), int'(ov_v[u]), 0);
    check($sformatf("u%0d.%s.busy", u, tag), int'(bz_v[u]), 0);
    check($sformatf("u%0d.%s.data", u, tag), get_data(u), 0);
    check($sformatf("u%0d.%s.fe", u, tag), int'(fe_v[u]), 0);
    check($sformatf("u%0d.%s.pe", u, tag), int'(pe_v[u]), 0);
  endtask

  task automatic drive(input int u, input bit lvl, input int n);
    rx_v[u] = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Serialises one character and records what a correct receiver must store.
  task automatic send_frame(input int u, input int d, input bit bad_par, input int stop_mask);
    int   m;
    bit   p;
    ent_t e;
    m = d & ((1 << DB[u]) - 1);
    drive(u, 1'b0, CPB[u]);
    for (int i = 0; i < DB[u]; i++) drive(u, m[i], CPB[u]);
    if (PAR[u] != 0) begin
      p = ($countones(m) % 2) == 1;
      if (PAR[u] == 1) p = !p;
      if (bad_par) p = !p;
      drive(u, p, CPB[u]);
    end
    for (int s = 0; s < SB[u]; s++) drive(u, !stop_mask[s], CPB[u]);
    drive(u, 1'b1, 4);
    e.d  = 9'(m);
    e.fe = (stop_mask & ((1 << SB[u]) - 1)) != 0;
    e.pe = (PAR[u] != 0) && bad_par;
    if (mq[u].size() == DEP[u]) ovr_m[u] = 1'b1;
    else                        mq[u].push_back(e);
  endtask

  task automatic pop(input int u);
    rd_v[u] = 1'b1;
    @(negedge clk);
    rd_v[u] = 1'b0;
    if (mq[u].size() > 0) void'(mq[u].pop_front());
    @(negedge clk);
  endtask

  task automatic clr(input int u);
    oc_v[u] = 1'b1;
    @(negedge clk);
    oc_v[u] = 1'b0;
    ovr_m[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) begin
      mq[u].delete();
      ovr_m[u] = 1'b0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int mask;
    rx_v  = 3'b111;
    rd_v  = 3'b000;
    oc_v  = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) reset_check(u, "por");

    // 8N1 0x55, then pop
    send_frame(0, 'h55, 1'b0, 0);
    compare_state(0, "c55");
    pop(0);
    compare_state(0, "c55_pop");

    // 0.4-bit glitch must be rejected as a false start
    drive(0, 1'b0, 42);
    check("u0.glitch.busy_high", int'(bz_v[0]), 1);
    drive(0, 1'b1, 2 * CPB[0]);
    compare_state(0, "glitch");

    // low stop bit, then a 12-bit break
    send_frame(0, 'hA3, 1'b0, 1);
    drive(0, 1'b0, 12 * CPB[0]);
    drive(0, 1'b1, 2 * CPB[0]);
    mq[0].push_back('{d: 9'h000, fe: 1'b1, pe: 1'b0});
    compare_state(0, "brk1");
    pop(0);
    compare_state(0, "brk2");
    pop(0);
    compare_state(0, "brk3");

    // reset in the middle of data bit 3 of 0x7E
    drive(0, 1'b0, CPB[0]);
    drive(0, 1'b0, CPB[0]);
    drive(0, 1'b1, CPB[0]);
    drive(0, 1'b1, CPB[0]);
    drive(0, 1'b1, CPB[0] / 2);
    check("u0.prereset.busy", int'(bz_v[0]), 1);
    pulse_reset();
    check("u0.postreset.busy", int'(bz_v[0]), 0);
    drive(0, 1'b1, 12 * CPB[0]);
    for (int u = 0; u < 3; u++) reset_check(u, "midrst");
    send_frame(0, 'h12, 1'b0, 0);
    compare_state(0, "c12");
    pop(0);

    // even parity: 0x41 with wrong then right parity bit, then low second stop bit
    send_frame(1, 'h41, 1'b1, 0);
    send_frame(1, 'h41, 1'b0, 0);
    compare_state(1, "par1");
    pop(1);
    compare_state(1, "par2");
    pop(1);
    send_frame(1, 'h2C, 1'b0, 2);
    compare_state(1, "stop2");
    pop(1);
    compare_state(1, "stop2_pop");

    // fill a 4-deep FIFO with five characters
    for (int k = 0; k < 5; k++) send_frame(1, int'($urandom), 1'b0, 0);
    compare_state(1, "ovr");
    clr(1);
    compare_state(1, "ovr_clr");
    for (int k = 0; k < 4; k++) begin
      compare_state(1, $sformatf("drain%0d", k));
      pop(1);
    end
    compare_state(1, "drained");

    // random traffic on every configuration
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < ((u == 0) ? 6 : 20); k++) begin
        d    = int'($urandom);
        mask = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (1 << SB[u]) - 1)) : 0;
        send_frame(u, d, $urandom_range(0, 3) == 0, mask);
        compare_state(u, $sformatf("rnd%0d", k));
        if (ovr_m[u] && $urandom_range(0, 1) == 1) begin
          clr(u);
          compare_state(u, $sformatf("rndclr%0d", k));
        end
        for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
          pop(u);
          compare_state(u, $sformatf("rndpop%0d_%0d", k, r));
        end
      end
      while (mq[u].size() > 0) pop(u);
      pop(u);
      compare_state(u, "rnd_end");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
